// File: rtl/imm_field_packer.sv
// imm_field_packer
//
// Encodes a 64-bit two's-complement immediate into a 26-bit instruction
// field for one of four formats. It flags values that do not fit the format
// and holds up to two encoded words in a small in-order buffer.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   in_valid   - producer offers a word
//   in_ready   - buffer can take a word this cycle (registered state only)
//   in_imm     - 64-bit immediate to encode
//   in_fmt     - 00 ALU-imm, 01 DT-address, 10 branch, 11 cond-branch
//   out_valid  - head word present
//   out_ready  - consumer takes the head word
//   out_field  - packed 26-bit field of the head word
//   out_fmt    - format of the head word
//   out_err    - head word was not representable in its format
//   err_clr    - synchronous clear of err_cnt (wins over an increment)
//   err_cnt    - saturating count of accepted words with a range error

module imm_field_packer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_imm,
    input  logic [1:0]       in_fmt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [25:0]      out_field,
    output logic [1:0]       out_fmt,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t state;
    buf_state_t state_next;

    // Slot 0 is always the oldest word; slot 1 is only meaningful in FULL.
    logic [25:0] slot0_field;
    logic [1:0]  slot0_fmt;
    logic        slot0_err;
    logic [25:0] slot1_field;
    logic [1:0]  slot1_fmt;
    logic        slot1_err;

    logic [25:0] pack_field;
    logic        pack_err;
    logic        push;
    logic        pop;

    // Handshakes depend only on the registered state, so in_ready has no
    // path from out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_field = slot0_field;
    assign out_fmt   = slot0_fmt;
    assign out_err   = slot0_err;

    // Bitwise packing of the incoming word. A signed range check is the same
    // as requiring every bit above the field to match the field's top bit.
    // Out-of-range words are still packed (truncated) and only flagged.
    always_comb begin
        pack_field = '0;
        pack_err   = 1'b0;
        unique case (in_fmt)
            2'b00: begin
                pack_field[21:10] = in_imm[11:0];
                pack_err          = |in_imm[63:12];
            end
            2'b01: begin
                pack_field[20:12] = in_imm[8:0];
                pack_err          = !((&in_imm[63:8]) || !(|in_imm[63:8]));
            end
            2'b10: begin
                pack_field[25:0] = in_imm[25:0];
                pack_err         = !((&in_imm[63:25]) || !(|in_imm[63:25]));
            end
            default: begin
                pack_field[23:5] = in_imm[20:2];
                pack_err         = (|in_imm[1:0]) ||
                                   !((&in_imm[63:20]) || !(|in_imm[63:20]));
            end
        endcase
    end

    // Buffer occupancy transitions. FULL never sees a push because in_ready
    // is low there.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (push) state_next = ONE;
            end
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (!push && pop) state_next = EMPTY;
            end
            FULL: begin
                if (pop) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_next;
    end

    // Word storage. A new word goes to slot 0 whenever slot 0 is (or is
    // becoming) free, otherwise behind it in slot 1. Popping from FULL
    // shifts slot 1 forward so the head always sits in slot 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot0_field <= '0;
            slot0_fmt   <= '0;
            slot0_err   <= 1'b0;
            slot1_field <= '0;
            slot1_fmt   <= '0;
            slot1_err   <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        slot0_field <= pack_field;
                        slot0_fmt   <= in_fmt;
                        slot0_err   <= pack_err;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        slot0_field <= pack_field;
                        slot0_fmt   <= in_fmt;
                        slot0_err   <= pack_err;
                    end else if (push) begin
                        slot1_field <= pack_field;
                        slot1_fmt   <= in_fmt;
                        slot1_err   <= pack_err;
                    end
                end
                FULL: begin
                    if (pop) begin
                        slot0_field <= slot1_field;
                        slot0_fmt   <= slot1_fmt;
                        slot0_err   <= slot1_err;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating error counter; a clear in the same cycle beats an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (push && pack_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_field_packer.sv
// tb_imm_field_packer
//
// Scoreboard bench for imm_field_packer. The stimulus side pushes the
// expected word for every accepted input. A separate monitor pops and
// compares whenever the DUT hands a word to the consumer. Expected values
// come from an arithmetic reference model or from literal reference vectors.

module tb_imm_field_packer;

    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_imm;
    logic [1:0]       in_fmt;
    logic             out_valid;
    logic             out_ready;
    logic [25:0]      out_field;
    logic [1:0]       out_fmt;
    logic             out_err;
    logic             err_clr;
    logic [CNT_W-1:0] err_cnt;

    typedef struct packed {
        logic [25:0] field;
        logic [1:0]  fmt;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    logic hold_out = 1'b0;

    imm_field_packer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_fmt    (in_fmt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_fmt   (out_fmt),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model built from the value ranges each format can hold:
    // fields are obtained by modulo/scale arithmetic, errors by signed or
    // unsigned range comparisons.
    function automatic exp_t model(input logic [63:0] imm, input logic [1:0] fmt);
        exp_t   e;
        longint s;
        logic [63:0] f;
        s = imm;
        e.fmt = fmt;
        case (fmt)
            2'b00: begin
                f     = (imm % 64'd4096) * 64'd1024;
                e.err = (imm >= 64'd4096);
            end
            2'b01: begin
                f     = (imm % 64'd512) * 64'd4096;
                e.err = (s < -64'sd256) || (s > 64'sd255);
            end
            2'b10: begin
                f     = imm % 64'd67108864;
                e.err = (s < -64'sd33554432) || (s > 64'sd33554431);
            end
            default: begin
                f     = ((imm % 64'd2097152) / 64'd4) * 64'd32;
                e.err = ((imm % 64'd4) != 64'd0) ||
                        (s < -64'sd1048576) || (s > 64'sd1048575);
            end
        endcase
        e.field = f[25:0];
        return e;
    endfunction

    // One stimulus cycle: check the counter, drive inputs after the falling
    // edge, then record what the next rising edge will accept.
    task automatic apply_stimulus(input logic v, input logic [63:0] imm,
                                  input logic [1:0] fmt, input logic clr,
                                  input exp_t e, output logic acc);
        @(negedge clk);
        check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
        in_valid = v;
        in_imm   = imm;
        in_fmt   = fmt;
        err_clr  = clr;
        #1;
        acc = v && in_ready && reset_n;
        if (acc) q.push_back(e);
        if (!reset_n || clr)                     exp_cnt = 0;
        else if (acc && e.err && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic idle_cycle();
        logic acc;
        exp_t e;
        e = '0;
        apply_stimulus(1'b0, 64'd0, 2'b00, 1'b0, e, acc);
    endtask

    task automatic send_word(input logic [63:0] imm, input logic [1:0] fmt,
                             input logic clr, input exp_t e);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            apply_stimulus(1'b1, imm, fmt, clr, e, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int cycles;
        cycles = 0;
        while ((q.size() != 0 || out_valid) && cycles < 200) begin
            idle_cycle();
            cycles++;
        end
        check("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [63:0] rand_imm();
        logic [63:0] v;
        longint      sv;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: begin
                sv = longint'($signed($urandom)) >>> $urandom_range(0, 31);
                v  = sv;
            end
            2: v = 64'($urandom_range(0, 5000));
            default: begin
                sv = longint'($signed($urandom)) >>> $urandom_range(8, 31);
                v  = sv & ~64'd3;
            end
        endcase
        return v;
    endfunction

    // Monitor: decides consumer readiness after each falling edge and checks
    // the head word whenever a transfer will happen on the next rising edge.
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
            #2;
            if (reset_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_word", 64'(out_field), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    check("out_field", 64'(out_field), 64'(e.field));
                    check("out_fmt",   64'(out_fmt),   64'(e.fmt));
                    check("out_err",   64'(out_err),   64'(e.err));
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic acc;
        int   n_acc;
        logic [63:0] imm;
        logic [1:0]  fmt;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_imm   = '0;
        in_fmt   = '0;
        err_clr  = 1'b0;
        #12;
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_field", 64'(out_field), 64'd0);
        check("reset_err_cnt",   64'(err_cnt),   64'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Reference vectors with literal expected results.
        e = '{field: 26'h02AF000, fmt: 2'b00, err: 1'b0};
        send_word(64'h0000000000000ABC, 2'b00, 1'b0, e);
        e = '{field: 26'h0000000, fmt: 2'b00, err: 1'b1};
        send_word(64'h0000000000001000, 2'b00, 1'b0, e);
        e = '{field: 26'h0100000, fmt: 2'b01, err: 1'b0};
        send_word(64'hFFFFFFFFFFFFFF00, 2'b01, 1'b0, e);
        e = '{field: 26'h0100000, fmt: 2'b01, err: 1'b1};
        send_word(64'h0000000000000100, 2'b01, 1'b0, e);
        e = '{field: 26'h0FFFFE0, fmt: 2'b11, err: 1'b0};
        send_word(64'hFFFFFFFFFFFFFFFC, 2'b11, 1'b0, e);
        e = '{field: 26'h0000020, fmt: 2'b11, err: 1'b1};
        send_word(64'h0000000000000006, 2'b11, 1'b0, e);
        e = '{field: 26'h2000000, fmt: 2'b10, err: 1'b1};
        send_word(64'h0000000002000000, 2'b10, 1'b0, e);
        wait_drain();
        check("err_cnt_vectors", 64'(err_cnt), 64'd4);

        // Random traffic against the model, with occasional counter clears.
        for (int i = 0; i < 400; i++) begin
            imm = rand_imm();
            fmt = 2'($urandom_range(0, 3));
            apply_stimulus($urandom_range(0, 3) != 0, imm, fmt,
                           $urandom_range(0, 19) == 0, model(imm, fmt), acc);
        end
        wait_drain();

        // Backpressure: only two words fit; the third waits for a pop.
        hold_out = 1'b1;
        idle_cycle();
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            imm = 64'(100 + i);
            apply_stimulus(1'b1, imm, 2'b10, 1'b0, model(imm, 2'b10), acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", 64'(n_acc), 64'd2);
        #2;
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        hold_out = 1'b0;
        send_word(64'd102, 2'b10, 1'b0, model(64'd102, 2'b10));
        wait_drain();

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            imm = 64'h1000 + 64'(i);
            send_word(imm, 2'b00, 1'b0, model(imm, 2'b00));
        end
        idle_cycle();
        check("err_cnt_saturated", 64'(err_cnt), 64'(CNT_MAX));

        // Clear wins over an increment in the same cycle.
        send_word(64'h5000, 2'b00, 1'b1, model(64'h5000, 2'b00));
        idle_cycle();
        check("err_cnt_clear_wins", 64'(err_cnt), 64'd0);
        wait_drain();

        // Asynchronous reset while FULL discards buffered words.
        send_word(64'h2000, 2'b00, 1'b0, model(64'h2000, 2'b00));
        wait_drain();
        hold_out = 1'b1;
        idle_cycle();
        send_word(64'd7, 2'b00, 1'b0, model(64'd7, 2'b00));
        send_word(64'd8, 2'b00, 1'b0, model(64'd8, 2'b00));
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready",  64'(in_ready),  64'd1);
        check("async_rst_out_field", 64'(out_field), 64'd0);
        check("async_rst_out_fmt",   64'(out_fmt),   64'd0);
        check("async_rst_out_err",   64'(out_err),   64'd0);
        check("async_rst_err_cnt",   64'(err_cnt),   64'd0);
        q.delete();
        exp_cnt = 0;
        idle_cycle();
        idle_cycle();
        @(posedge clk);
        #3 reset_n = 1'b1;
        hold_out = 1'b0;
        imm = 64'h0000000000000123;
        send_word(imm, 2'b01, 1'b0, model(imm, 2'b01));
        wait_drain();
        idle_cycle();
        check("final_queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_field_packer.md
IMM_FIELD_PACKER -- requirements
Module: imm_field_packer

Interface
REQ-001 CNT_W, 8, width of the saturating range-error counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  producer offers a word.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_imm  input  64  immediate value to encode, two's complement.
REQ-007 in_fmt  input  2  format: 00 ALU-imm, 01 DT-address, 10 branch, 11 cond-branch.
REQ-008 out_valid  output  1  head word present.
REQ-009 out_ready  input  1  consumer takes the head word.
REQ-010 out_field  output  26  packed instruction field, bits [25:0].
REQ-011 out_fmt  output  2  format of the head word.
REQ-012 out_err  output  1  head word not representable in its format.
REQ-013 err_clr  input  1  synchronous clear of err_cnt.
REQ-014 err_cnt  output  CNT_W  count of accepted words with a range error.

Function
REQ-015 The block SHALL transfer an input word when in_valid and in_ready are both 1 on a rising edge, and an output word when out_valid and out_ready are both 1.
REQ-016 Packing SHALL be purely bitwise per format; all field bits not listed SHALL be 0:
- 00: field[21:10]=imm[11:0]; err iff imm[63:12]!=0.
- 01: field[20:12]=imm[8:0]; err iff imm[63:9] not all equal to imm[8].
- 10: field[25:0]=imm[25:0]; err iff imm[63:26] not all equal to imm[25].
- 11: field[23:5]=imm[20:2]; err iff imm[1:0]!=0 or imm[63:21] not all equal to imm[20].
REQ-017 On err, the truncated packing SHALL still be output unchanged; err SHALL NOT block or drop the word.
REQ-018 Packing and err SHALL be computed at input acceptance and stored with the word in a 2-entry buffer.
REQ-019 The buffer state machine SHALL have three states: EMPTY, ONE, FULL.
REQ-020 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL. It SHALL be derived only from registered state, with no combinational path from out_ready.
REQ-022 out_valid SHALL be 1 in ONE and FULL. out_field, out_fmt and out_err SHALL show the oldest word and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Latency SHALL be 1 cycle: a word accepted in EMPTY appears on the outputs in the next cycle.
REQ-024 Words SHALL leave in acceptance order, with no loss or duplication.
REQ-025 err_cnt SHALL increment by 1 for each accepted word whose err=1, and SHALL saturate at 2^CNT_W-1.
REQ-026 If err_clr is 1 in the same cycle as an increment, the clear SHALL win and err_cnt SHALL become 0.

Reset
REQ-027 reset_n=0 SHALL immediately force state EMPTY, in_ready=1, out_valid=0, out_field=0, out_fmt=0, out_err=0 and err_cnt=0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words. After reset_n rises, no stale word SHALL appear.

Verification
REQ-029 fmt 00, imm 0x0000000000000ABC -> out_field 0x02AF000, out_err 0; imm 0x1000 -> out_field 0, out_err 1, err_cnt+1.
REQ-030 fmt 01, imm 0xFFFFFFFFFFFFFF00 -> out_field 0x0100000, out_err 0; imm 0x100 -> out_field 0x0100000, out_err 1.
REQ-031 fmt 11, imm 0xFFFFFFFFFFFFFFFC -> out_field 0x0FFFFE0, out_err 0; imm 0x6 -> out_err 1. Fmt 10, imm 0x0000000002000000 -> out_field 0x2000000, out_err 1.
REQ-032 out_ready=0, offer 3 words back-to-back -> 2 accepted, in_ready=0 in FULL. Raise out_ready -> words drain in order, and the 3rd word is accepted once the state returns to ONE.
REQ-033 CNT_W=8, 300 erroneous words -> err_cnt holds at 255. err_clr on a cycle with an erroneous accept -> err_cnt=0.
REQ-034 Assert reset_n=0 asynchronously while FULL -> out_valid=0 and in_ready=1 before the next clk edge. After release, first output is the first post-reset word.
